// File: rtl/video_timing_detect.sv
// video_timing_detect
//   Measures active width/height and total line/frame size of the incoming
//   pixel-clock-domain video timing (after LVDS deserialization). It declares
//   lock after P_STABLE_FRAMES identical consistent frames. It drops lock on a
//   format change, an inconsistent frame or a vsync timeout.
// Ports
//   w_pixel_clk, i_rst_n (async, active-low)
//   i_video_vsync/hsync/de : raw sync inputs, active-high
//   o_h_active/o_v_active/o_h_total/o_v_total : geometry captured at lock entry
//   o_locked, o_lock_lost (1-cycle), o_frame_start (1-cycle), o_frame_cnt
module video_timing_detect #(
    parameter int P_STABLE_FRAMES  = 4,
    parameter int P_TIMEOUT_CYCLES = 'd7_425_000
) (
    input  logic        w_pixel_clk,
    input  logic        i_rst_n,
    input  logic        i_video_vsync,
    input  logic        i_video_hsync,
    input  logic        i_video_de,
    output logic [11:0] o_h_active,
    output logic [11:0] o_v_active,
    output logic [12:0] o_h_total,
    output logic [11:0] o_v_total,
    output logic        o_locked,
    output logic        o_lock_lost,
    output logic        o_frame_start,
    output logic [15:0] o_frame_cnt
);
    localparam int              WD_W     = $clog2(P_TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_END   = WD_W'(P_TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_PRE   = WD_W'(P_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      STABLE_N = 4'(P_STABLE_FRAMES);

    typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_LOCKED} state_t;

    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    function automatic logic [12:0] sat_inc13(input logic [12:0] v);
        return (v == 13'h1FFF) ? v : v + 13'd1;
    endfunction

    logic        vs_s1_q, vs_s2_q, hs_s1_q, hs_s2_q, de_s1_q, de_s2_q;
    logic        vs_rise, hs_rise, de_rise, de_fall;

    logic [12:0] pix_cnt_q, pix_cnt_d;
    logic        pix_vld_q, pix_vld_d;
    logic [11:0] de_cnt_q, de_cnt_d;
    logic        de_run_q, de_run_d;
    logic [11:0] line_cnt_q, line_cnt_d, act_cnt_q, act_cnt_d;
    logic [12:0] first_ln_q, first_ln_d;
    logic        first_ln_vld_q, first_ln_vld_d;
    logic [11:0] first_de_q, first_de_d;
    logic        first_de_vld_q, first_de_vld_d;
    logic        bad_q, bad_d;

    logic        ln_stb, de_stb, sat_now, frame_bad;
    logic [12:0] ln_len;

    state_t      state_q, state_d;
    logic [3:0]  stable_q, stable_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [11:0] cand_hact_q, cand_hact_d, cand_vact_q, cand_vact_d;
    logic [12:0] cand_htot_q, cand_htot_d;
    logic [11:0] cand_vtot_q, cand_vtot_d;
    logic        cand_eq;

    logic [11:0] h_act_q, h_act_d, v_act_q, v_act_d, v_tot_q, v_tot_d;
    logic [12:0] h_tot_q, h_tot_d;
    logic        locked_q, locked_d, lost_q, lost_d, fstart_q, fstart_d;
    logic [15:0] fcnt_q, fcnt_d;

    assign vs_rise = vs_s1_q & ~vs_s2_q;
    assign hs_rise = hs_s1_q & ~hs_s2_q;
    assign de_rise = de_s1_q & ~de_s2_q;
    assign de_fall = ~de_s1_q & de_s2_q;

    // Line/frame measurement. On a vs rise the per-frame state restarts, and
    // edges of that same cycle are folded into the new frame.
    always_comb begin
        // The first hs rise after reset closes a partial line, so it is not latched.
        ln_stb    = hs_rise & pix_vld_q;
        ln_len    = sat_inc13(pix_cnt_q);
        de_stb    = de_fall & de_run_q;
        sat_now   = (pix_cnt_q == '1) | (de_cnt_q == '1) |
                    (line_cnt_q == '1) | (act_cnt_q == '1);
        frame_bad = bad_q | sat_now;

        pix_cnt_d = hs_rise ? 13'd0 : sat_inc13(pix_cnt_q);
        pix_vld_d = pix_vld_q | hs_rise;

        de_run_d = de_run_q;
        de_cnt_d = de_cnt_q;
        if (de_rise) begin
            de_run_d = 1'b1;
            de_cnt_d = 12'd1;
        end else if (de_fall) begin
            de_run_d = 1'b0;
        end else if (de_s1_q && de_run_q) begin
            de_cnt_d = sat_inc12(de_cnt_q);
        end

        line_cnt_d     = vs_rise ? 12'd0 : line_cnt_q;
        act_cnt_d      = vs_rise ? 12'd0 : act_cnt_q;
        first_ln_d     = vs_rise ? 13'd0 : first_ln_q;
        first_ln_vld_d = ~vs_rise & first_ln_vld_q;
        first_de_d     = vs_rise ? 12'd0 : first_de_q;
        first_de_vld_d = ~vs_rise & first_de_vld_q;
        bad_d          = ~vs_rise & frame_bad;

        if (hs_rise) line_cnt_d = sat_inc12(line_cnt_d);
        if (de_rise) act_cnt_d  = sat_inc12(act_cnt_d);

        if (ln_stb) begin
            if (!first_ln_vld_d) begin
                first_ln_d     = ln_len;
                first_ln_vld_d = 1'b1;
            end else if (ln_len != first_ln_d) begin
                bad_d = 1'b1;
            end
        end
        if (de_stb) begin
            if (!first_de_vld_d) begin
                first_de_d     = de_cnt_q;
                first_de_vld_d = 1'b1;
            end else if (de_cnt_q != first_de_d) begin
                bad_d = 1'b1;
            end
        end
    end

    // Lock FSM and watchdog. The candidate of the frame that just ended is the
    // current first-de / act / first-line / line counter set.
    always_comb begin
        state_d     = state_q;
        stable_d    = stable_q;
        wd_d        = (wd_q == WD_END) ? wd_q : wd_q + WD_W'(1);
        cand_hact_d = cand_hact_q;
        cand_vact_d = cand_vact_q;
        cand_htot_d = cand_htot_q;
        cand_vtot_d = cand_vtot_q;
        h_act_d     = h_act_q;
        v_act_d     = v_act_q;
        h_tot_d     = h_tot_q;
        v_tot_d     = v_tot_q;
        locked_d    = locked_q;
        lost_d      = 1'b0;
        fstart_d    = 1'b0;
        fcnt_d      = fcnt_q;

        cand_eq = (first_de_q == cand_hact_q) && (act_cnt_q == cand_vact_q) &&
                  (first_ln_q == cand_htot_q) && (line_cnt_q == cand_vtot_q);

        if (vs_rise) begin
            wd_d        = '0;
            cand_hact_d = first_de_q;
            cand_vact_d = act_cnt_q;
            cand_htot_d = first_ln_q;
            cand_vtot_d = line_cnt_q;
            case (state_q)
                S_IDLE: begin
                    state_d  = S_MEASURE;
                    stable_d = 4'd0;
                end
                S_MEASURE: begin
                    if (frame_bad)                 stable_d = 4'd0;
                    else if (P_STABLE_FRAMES == 1) stable_d = 4'd1;
                    else if (cand_eq)              stable_d = stable_q + 4'd1;
                    else                           stable_d = 4'd1;
                    if (stable_d == STABLE_N) begin
                        state_d  = S_LOCKED;
                        h_act_d  = first_de_q;
                        v_act_d  = act_cnt_q;
                        h_tot_d  = first_ln_q;
                        v_tot_d  = line_cnt_q;
                        locked_d = 1'b1;
                        fcnt_d   = 16'd0;
                    end
                end
                S_LOCKED: begin
                    if (!frame_bad && cand_eq) begin
                        fstart_d = 1'b1;
                        fcnt_d   = fcnt_q + 16'd1;
                    end else begin
                        state_d  = S_MEASURE;
                        stable_d = frame_bad ? 4'd0 : 4'd1;
                        locked_d = 1'b0;
                        lost_d   = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (wd_q == WD_PRE) begin
            // Fires once on reaching the terminal count; the counter then holds.
            state_d  = S_IDLE;
            stable_d = 4'd0;
            locked_d = 1'b0;
            lost_d   = (state_q == S_LOCKED);
        end
    end

    always_ff @(posedge w_pixel_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vs_s1_q <= 1'b0; vs_s2_q <= 1'b0;
            hs_s1_q <= 1'b0; hs_s2_q <= 1'b0;
            de_s1_q <= 1'b0; de_s2_q <= 1'b0;
            pix_cnt_q <= '0; pix_vld_q <= 1'b0;
            de_cnt_q <= '0; de_run_q <= 1'b0;
            line_cnt_q <= '0; act_cnt_q <= '0;
            first_ln_q <= '0; first_ln_vld_q <= 1'b0;
            first_de_q <= '0; first_de_vld_q <= 1'b0;
            bad_q <= 1'b0;
            state_q <= S_IDLE; stable_q <= '0; wd_q <= '0;
            cand_hact_q <= '0; cand_vact_q <= '0;
            cand_htot_q <= '0; cand_vtot_q <= '0;
            h_act_q <= '0; v_act_q <= '0; h_tot_q <= '0; v_tot_q <= '0;
            locked_q <= 1'b0; lost_q <= 1'b0; fstart_q <= 1'b0; fcnt_q <= '0;
        end else begin
            vs_s1_q <= i_video_vsync; vs_s2_q <= vs_s1_q;
            hs_s1_q <= i_video_hsync; hs_s2_q <= hs_s1_q;
            de_s1_q <= i_video_de;    de_s2_q <= de_s1_q;
            pix_cnt_q <= pix_cnt_d; pix_vld_q <= pix_vld_d;
            de_cnt_q <= de_cnt_d; de_run_q <= de_run_d;
            line_cnt_q <= line_cnt_d; act_cnt_q <= act_cnt_d;
            first_ln_q <= first_ln_d; first_ln_vld_q <= first_ln_vld_d;
            first_de_q <= first_de_d; first_de_vld_q <= first_de_vld_d;
            bad_q <= bad_d;
            state_q <= state_d; stable_q <= stable_d; wd_q <= wd_d;
            cand_hact_q <= cand_hact_d; cand_vact_q <= cand_vact_d;
            cand_htot_q <= cand_htot_d; cand_vtot_q <= cand_vtot_d;
            h_act_q <= h_act_d; v_act_q <= v_act_d; h_tot_q <= h_tot_d; v_tot_q <= v_tot_d;
            locked_q <= locked_d; lost_q <= lost_d; fstart_q <= fstart_d; fcnt_q <= fcnt_d;
        end
    end

    assign o_h_active    = h_act_q;
    assign o_v_active    = v_act_q;
    assign o_h_total     = h_tot_q;
    assign o_v_total     = v_tot_q;
    assign o_locked      = locked_q;
    assign o_lock_lost   = lost_q;
    assign o_frame_start = fstart_q;
    assign o_frame_cnt   = fcnt_q;
endmodule
